// File: rtl/register_alu_sequencer.sv
// Four-cycle execute/write-back sequencer driving a 2R/1W register file.
// Rd doubles as first source and write target on the shared A port.
module register_alu_sequencer #(
  parameter int AddressWidth  = 6,
  parameter int RegisterWidth = 16
) (
  input  logic                     Clock,
  input  logic                     nReset,
  input  logic                     InValid,
  output logic                     InReady,
  input  logic [2:0]               Opcode,
  input  logic [AddressWidth-1:0]  DestAddr,
  input  logic [AddressWidth-1:0]  SrcAddr,
  input  logic [RegisterWidth-1:0] Immediate,
  output logic [AddressWidth-1:0]  RfAddressA,
  output logic [AddressWidth-1:0]  RfAddressB,
  output logic                     RfWriteEnable,
  output logic [RegisterWidth-1:0] RfWriteData,
  input  logic [RegisterWidth-1:0] RfReadDataA,
  input  logic [RegisterWidth-1:0] RfReadDataB,
  output logic                     Done,
  output logic                     Carry,
  output logic                     Zero
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    EXEC  = 2'd2,
    WRITE = 2'd3
  } state_e;

  localparam logic [2:0] OP_MOV  = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_LDI  = 3'b110;
  localparam logic [2:0] OP_ADDI = 3'b111;

  localparam int W = RegisterWidth;

  state_e                  state_q, state_d;
  logic [2:0]              op_q, op_d;
  logic [AddressWidth-1:0] rd_q, rd_d;
  logic [AddressWidth-1:0] rs_q, rs_d;
  logic [W-1:0]            imm_q, imm_d;
  logic [W-1:0]            opa_q, opa_d;
  logic [W-1:0]            opb_q, opb_d;
  logic [W-1:0]            res_q, res_d;
  logic                    cyn_q, cyn_d;
  logic                    zn_q, zn_d;
  logic                    carry_q, carry_d;
  logic                    zero_q, zero_d;

  logic [W:0]   alu_sum;
  logic [W:0]   alu_diff;
  logic [W-1:0] alu_res;
  logic         alu_cy;

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q <= IDLE;
      op_q    <= '0;
      rd_q    <= '0;
      rs_q    <= '0;
      imm_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      cyn_q   <= 1'b0;
      zn_q    <= 1'b0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      rs_q    <= rs_d;
      imm_q   <= imm_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      cyn_q   <= cyn_d;
      zn_q    <= zn_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
    end
  end

  // ADDI shares the adder with ADD; only the second operand differs.
  always_comb begin
    alu_sum  = {1'b0, opa_q}
             + {1'b0, (op_q == OP_ADDI) ? imm_q : opb_q};
    alu_diff = {1'b0, opa_q} - {1'b0, opb_q};
    alu_res  = '0;
    alu_cy   = 1'b0;
    unique case (op_q)
      OP_MOV:  alu_res = opb_q;
      OP_ADD,
      OP_ADDI: begin
        alu_res = alu_sum[W-1:0];
        alu_cy  = alu_sum[W];
      end
      OP_SUB: begin
        alu_res = alu_diff[W-1:0];
        alu_cy  = alu_diff[W];
      end
      OP_AND:  alu_res = opa_q & opb_q;
      OP_OR:   alu_res = opa_q | opb_q;
      OP_XOR:  alu_res = opa_q ^ opb_q;
      OP_LDI:  alu_res = imm_q;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rd_d    = rd_q;
    rs_d    = rs_q;
    imm_d   = imm_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    cyn_d   = cyn_q;
    zn_d    = zn_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    unique case (state_q)
      IDLE: begin
        if (InValid) begin
          op_d    = Opcode;
          rd_d    = DestAddr;
          rs_d    = SrcAddr;
          imm_d   = Immediate;
          state_d = READ;
        end
      end
      READ: begin
        opa_d   = RfReadDataA;
        opb_d   = RfReadDataB;
        state_d = EXEC;
      end
      EXEC: begin
        res_d   = alu_res;
        cyn_d   = alu_cy;
        zn_d    = (alu_res == '0);
        state_d = WRITE;
      end
      WRITE: begin
        carry_d = cyn_q;
        zero_d  = zn_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode from registers only; async reset clears WE at once.
  always_comb begin
    InReady       = 1'b0;
    RfAddressA    = '0;
    RfAddressB    = '0;
    RfWriteEnable = 1'b0;
    RfWriteData   = '0;
    Done          = 1'b0;
    unique case (state_q)
      IDLE: InReady = 1'b1;
      READ: begin
        RfAddressA = rd_q;
        RfAddressB = rs_q;
      end
      EXEC: ;
      WRITE: begin
        RfAddressA    = rd_q;
        RfWriteEnable = 1'b1;
        RfWriteData   = res_q;
        Done          = 1'b1;
      end
      default: ;
    endcase
  end

  assign Carry = carry_q;
  assign Zero  = zero_q;

endmodule

// File: tb/tb_register_alu_sequencer.sv
// Bench for register_alu_sequencer: register file + instruction-level
// reference model, per-cycle output compare, directed and random stimulus.
module tb_register_alu_sequencer;

  localparam int AW = 6;
  localparam int RW = 16;

  logic          Clock = 1'b0;
  logic          nReset;
  logic          InValid;
  logic          InReady;
  logic [2:0]    Opcode;
  logic [AW-1:0] DestAddr;
  logic [AW-1:0] SrcAddr;
  logic [RW-1:0] Immediate;
  logic [AW-1:0] RfAddressA;
  logic [AW-1:0] RfAddressB;
  logic          RfWriteEnable;
  logic [RW-1:0] RfWriteData;
  logic [RW-1:0] RfReadDataA;
  logic [RW-1:0] RfReadDataB;
  logic          Done;
  logic          Carry;
  logic          Zero;

  register_alu_sequencer #(
    .AddressWidth (AW),
    .RegisterWidth(RW)
  ) dut (
    .Clock        (Clock),
    .nReset       (nReset),
    .InValid      (InValid),
    .InReady      (InReady),
    .Opcode       (Opcode),
    .DestAddr     (DestAddr),
    .SrcAddr      (SrcAddr),
    .Immediate    (Immediate),
    .RfAddressA   (RfAddressA),
    .RfAddressB   (RfAddressB),
    .RfWriteEnable(RfWriteEnable),
    .RfWriteData  (RfWriteData),
    .RfReadDataA  (RfReadDataA),
    .RfReadDataB  (RfReadDataB),
    .Done         (Done),
    .Carry        (Carry),
    .Zero         (Zero)
  );

  always #5 Clock = ~Clock;

  // Register file: async read, write on rising edge, plus a preload port.
  logic [RW-1:0] rf [64];
  logic          pl_we = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [RW-1:0] pl_data = '0;

  assign RfReadDataA = rf[RfAddressA];
  assign RfReadDataB = rf[RfAddressB];

  always @(posedge Clock) begin
    if (RfWriteEnable) rf[RfAddressA] <= RfWriteData;
    else if (pl_we)    rf[pl_addr]    <= pl_data;
  end

  // Reference model: the result is fixed when the instruction is accepted,
  // and becomes visible 4 edges later.
  int            m_phase = 0;
  logic [RW-1:0] m_regs [64];
  logic [AW-1:0] m_rd = '0;
  logic [AW-1:0] m_rs = '0;
  logic [RW-1:0] m_res = '0;
  logic          m_cy_n = 1'b0;
  logic          m_carry = 1'b0;
  logic          m_zero = 1'b0;

  function automatic logic [RW:0] ref_exec(
    input logic [2:0] op, input logic [RW-1:0] rdv,
    input logic [RW-1:0] rsv, input logic [RW-1:0] imm);
    int a, b, s;
    logic [RW-1:0] r;
    logic c;
    a = int'(rdv);
    b = int'(rsv);
    c = 1'b0;
    case (op)
      3'd0: r = rsv;
      3'd1: begin s = a + b; r = RW'(s % 65536); c = (s > 65535); end
      3'd2: begin s = a - b + 65536; r = RW'(s % 65536); c = (a < b); end
      3'd3: r = rdv & rsv;
      3'd4: r = rdv | rsv;
      3'd5: r = rdv ^ rsv;
      3'd6: r = imm;
      default: begin
        s = a + int'(imm); r = RW'(s % 65536); c = (s > 65535);
      end
    endcase
    return {c, r};
  endfunction

  always @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      m_phase <= 0;
      m_carry <= 1'b0;
      m_zero  <= 1'b0;
    end else begin
      if (pl_we) m_regs[pl_addr] <= pl_data;
      if (m_phase == 0) begin
        if (InValid) begin
          m_phase <= 1;
          m_rd    <= DestAddr;
          m_rs    <= SrcAddr;
          {m_cy_n, m_res} <= ref_exec(Opcode, m_regs[DestAddr],
                                      m_regs[SrcAddr], Immediate);
        end
      end else if (m_phase == 3) begin
        m_regs[m_rd] <= m_res;
        m_carry      <= m_cy_n;
        m_zero       <= (m_res == '0);
        m_phase      <= 0;
      end else begin
        m_phase <= m_phase + 1;
      end
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle_check();
    logic [32:0] act, exp;
    act = {InReady, RfAddressA, RfAddressB, RfWriteEnable,
           RfWriteData, Done, Carry, Zero};
    case (m_phase)
      0: exp = {1'b1, 6'd0, 6'd0, 1'b0, 16'd0, 1'b0, m_carry, m_zero};
      1: exp = {1'b0, m_rd, m_rs, 1'b0, 16'd0, 1'b0, m_carry, m_zero};
      2: exp = {1'b0, 6'd0, 6'd0, 1'b0, 16'd0, 1'b0, m_carry, m_zero};
      default:
         exp = {1'b0, m_rd, 6'd0, 1'b1, m_res, 1'b1, m_carry, m_zero};
    endcase
    chk("cycle_outputs", 64'(act), 64'(exp));
  endtask

  task automatic tick();
    @(negedge Clock);
    if (nReset) cycle_check();
  endtask

  task automatic preload(input int a, input logic [RW-1:0] d);
    pl_we   = 1'b1;
    pl_addr = AW'(a);
    pl_data = d;
    tick();
    pl_we   = 1'b0;
  endtask

  task automatic run(input logic [2:0] op, input int rd, input int rs,
                     input logic [RW-1:0] imm);
    InValid   = 1'b1;
    Opcode    = op;
    DestAddr  = AW'(rd);
    SrcAddr   = AW'(rs);
    Immediate = imm;
    tick();
    InValid   = 1'b0;
    Opcode    = 3'($urandom);
    DestAddr  = AW'($urandom);
    SrcAddr   = AW'($urandom);
    Immediate = RW'($urandom);
    repeat (3) tick();
  endtask

  initial begin
    nReset    = 1'b0;
    InValid   = 1'b0;
    Opcode    = '0;
    DestAddr  = '0;
    SrcAddr   = '0;
    Immediate = '0;
    repeat (3) @(negedge Clock);
    chk("reset_outputs",
        64'({InReady, RfAddressA, RfAddressB, RfWriteEnable,
             RfWriteData, Done, Carry, Zero}),
        64'({1'b1, 6'd0, 6'd0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0}));
    nReset = 1'b1;

    for (int i = 0; i < 64; i++) preload(i, RW'($urandom));
    preload(1, 16'h0005);
    preload(2, 16'h0003);
    preload(4, 16'h0002);
    preload(5, 16'h0003);
    preload(3, 16'h4000);

    run(3'd1, 1, 2, 16'h0);
    chk("add_r1", 64'(rf[1]), 64'h0008);
    chk("add_flags", 64'({Carry, Zero}), 64'b00);

    preload(1, 16'hFFFF);
    run(3'd7, 1, 0, 16'h0001);
    chk("addi_r1", 64'(rf[1]), 64'h0000);
    chk("addi_flags", 64'({Carry, Zero}), 64'b11);

    run(3'd2, 4, 5, 16'h0);
    chk("sub_r4", 64'(rf[4]), 64'hFFFF);
    chk("sub_flags", 64'({Carry, Zero}), 64'b10);

    run(3'd6, 63, 7, 16'hA5A5);
    chk("ldi_r63", 64'(rf[63]), 64'hA5A5);
    run(3'd0, 0, 63, 16'h0);
    chk("mov_r0", 64'(rf[0]), 64'hA5A5);
    chk("mov_carry", 64'(Carry), 64'h0);

    run(3'd1, 3, 3, 16'h0);
    chk("add_self_r3", 64'(rf[3]), 64'h8000);
    chk("add_self_flags", 64'({Carry, Zero}), 64'b00);

    // Reset while an ADD sits in WRITE: nothing may be committed.
    preload(2, 16'h1234);
    InValid  = 1'b1;
    Opcode   = 3'd1;
    DestAddr = 6'd2;
    SrcAddr  = 6'd2;
    tick();
    InValid = 1'b0;
    tick();
    tick();
    chk("pre_reset_we", 64'(RfWriteEnable), 64'h1);
    #1 nReset = 1'b0;
    #1;
    chk("reset_we_async", 64'(RfWriteEnable), 64'h0);
    chk("reset_mid_outputs",
        64'({InReady, RfAddressA, RfAddressB, RfWriteData,
             Done, Carry, Zero}),
        64'({1'b1, 6'd0, 6'd0, 16'd0, 1'b0, 1'b0, 1'b0}));
    tick();
    nReset = 1'b1;
    tick();
    chk("reset_r2_kept", 64'(rf[2]), 64'h1234);

    for (int i = 0; i < 400; i++) begin
      InValid   = ($urandom_range(3) != 0);
      Opcode    = 3'($urandom);
      DestAddr  = AW'($urandom);
      SrcAddr   = AW'($urandom);
      Immediate = RW'($urandom);
      tick();
    end
    InValid = 1'b0;
    repeat (5) tick();

    for (int i = 0; i < 64; i++)
      chk($sformatf("final_r%0d", i), 64'(rf[i]), 64'(m_regs[i]));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
